uart_frame_rx: RTL



---
 rtl/uart_frame_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - header-hunting fixed-length frame assembler with additive checksum
module uart_frame_rx #(
    parameter int          FRAME_BYTES    = 40,
    parameter logic [7:0]  HEADER0        = 8'hEB,
    parameter logic [7:0]  HEADER1        = 8'h90,
    parameter int          GAP_CYCLES     = 2000,
    parameter int          TIMEOUT_CYCLES = 5000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [8*FRAME_BYTES-1:0] rx_frame,
    output logic                     rx_frame_done,
    output logic                     check_sum_error,
    output logic                     comNoResponse
);

    localparam int BW = 8 * (FRAME_BYTES - 2);
    localparam int IW = $clog2(FRAME_BYTES);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, HDR1, BODY} state_t;

    state_t          state, state_nxt;
    // Header bytes are constants, so only the bytes after them are stored.
    logic [BW-1:0]   body_sr;
    logic [IW-1:0]   idx;
    logic [7:0]      acc;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   to_cnt;
    logic            pend_good, pend_bad;
    logic            hdr_ok, body_byte, last_byte, gap_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hdr_ok    = 1'b0;
        body_byte = 1'b0;
        last_byte = 1'b0;
        gap_abort = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == HEADER0) state_nxt = HDR1;
            end
            HDR1: begin
                if (rx_valid) begin
                    if (rx_data == HEADER1) begin
                        state_nxt = BODY;
                        hdr_ok    = 1'b1;
                    end else if (rx_data != HEADER0) begin
                        state_nxt = IDLE;
                    end
                end else if (gap_cnt == GAP_LAST) begin
                    gap_abort = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BODY: begin
                if (rx_valid) begin
                    body_byte = 1'b1;
                    if (idx == LAST_IDX) begin
                        last_byte = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (gap_cnt == GAP_LAST) begin
                    gap_abort = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            body_sr         <= '0;
            idx             <= '0;
            acc             <= '0;
            gap_cnt         <= '0;
            to_cnt          <= '0;
            pend_good       <= 1'b0;
            pend_bad        <= 1'b0;
            rx_frame        <= '0;
            rx_frame_done   <= 1'b0;
            check_sum_error <= 1'b0;
        end else begin
            if (state == IDLE || rx_valid || gap_abort) gap_cnt <= '0;
            else                                        gap_cnt <= gap_cnt + 1'b1;

            if (hdr_ok) begin
                idx <= IW'(2);
                acc <= '0;
            end else if (gap_abort) begin
                idx <= '0;
            end else if (body_byte) begin
                body_sr <= {body_sr[BW-9:0], rx_data};
                if (last_byte) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                    acc <= acc + rx_data;
                end
            end

            // Completion is flagged here and applied to the outputs one edge later.
            pend_good     <= last_byte && (rx_data == acc);
            pend_bad      <= last_byte && (rx_data != acc);
            rx_frame_done <= pend_good;
            if (pend_good) begin
                rx_frame        <= {HEADER0, HEADER1, body_sr};
                check_sum_error <= 1'b0;
            end else if (pend_bad) begin
                check_sum_error <= 1'b1;
            end

            if (pend_good)             to_cnt <= '0;
            else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
        end
    end

    assign comNoResponse = (to_cnt == TO_MAX);

endmodule
